// File: rtl/darksocv_uart_agent.sv
// rtl/darksocv_uart_agent.sv - UART TX driver and RX decoder with FWFT FIFO for the darksocv bench
// Even parity in both directions when DARKSOCV_UART_AGENT_PARITY_EN is defined.
module darksocv_uart_agent #(
    parameter int DIV        = 868,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        XCLK,
    input  logic                        XRES,
    input  logic                        UART_TXD_IN,
    output logic                        UART_RXD_OUT,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] rx_level,
    output logic                        frame_err,
    output logic                        overrun,
    input  logic                        clr_err
);
`ifdef DARKSOCV_UART_AGENT_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] DIV_PRE   = CW'(DIV - 2);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

    tx_state_t            tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [3:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;

    always_ff @(posedge XCLK) begin
        if (!XRES) begin
            tx_state     <= TX_IDLE;
            UART_RXD_OUT <= 1'b1;
            tx_ready     <= 1'b1;
            tx_cnt       <= '0;
            tx_bit       <= '0;
            tx_shift     <= '0;
            tx_par       <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_shift     <= tx_data;
                        tx_par       <= ^tx_data;
                        UART_RXD_OUT <= 1'b0;
                        tx_ready     <= 1'b0;
                        tx_cnt       <= '0;
                        tx_state     <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt       <= '0;
                        tx_bit       <= '0;
                        UART_RXD_OUT <= tx_shift[0];
                        tx_shift     <= tx_shift >> 1;
                        tx_state     <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == BIT_LAST) begin
                            tx_bit <= '0;
                            if (PARITY) begin
                                UART_RXD_OUT <= tx_par;
                                tx_state     <= TX_PAR;
                            end else begin
                                UART_RXD_OUT <= 1'b1;
                                tx_state     <= TX_STOP;
                            end
                        end else begin
                            tx_bit       <= tx_bit + 1'b1;
                            UART_RXD_OUT <= tx_shift[0];
                            tx_shift     <= tx_shift >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_PAR: begin
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt       <= '0;
                        UART_RXD_OUT <= 1'b1;
                        tx_state     <= TX_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    // Ready is raised during the last stop-bit cycle so a
                    // back-to-back byte starts right after it.
                    if (tx_bit == STOP_LAST && tx_cnt == DIV_PRE) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_ready <= 1'b1;
                        tx_state <= TX_IDLE;
                    end else if (tx_cnt == DIV_LAST) begin
                        tx_cnt <= '0;
                        tx_bit <= tx_bit + 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // [1:0] synchronise the line, [2] is the previous synchronised value
    logic [2:0] rx_sync;
    logic       rx_in;
    logic       rx_prev;
    assign rx_in   = rx_sync[1];
    assign rx_prev = rx_sync[2];

    always_ff @(posedge XCLK) begin
        if (!XRES) rx_sync <= '1;
        else       rx_sync <= {rx_sync[1:0], UART_TXD_IN};
    end

    rx_state_t            rx_state;
    logic [CW-1:0]        rx_cnt;
    logic [3:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bad;
    logic                 rx_push;
    logic                 fe_set;

    always_comb begin
        rx_push = 1'b0;
        fe_set  = 1'b0;
        if (rx_state == RX_STOP && rx_cnt == DIV_LAST) begin
            if (rx_in && !rx_par_bad) rx_push = 1'b1;
            else                      fe_set  = 1'b1;
        end
    end

    always_ff @(posedge XCLK) begin
        if (!XRES) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par_bad <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_in) begin
                        rx_cnt     <= '0;
                        rx_par_bad <= 1'b0;
                        rx_state   <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_in ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_in, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == BIT_LAST) rx_state <= PARITY ? RX_PAR : RX_STOP;
                        else                    rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_PAR: begin
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt     <= '0;
                        rx_par_bad <= rx_in != ^rx_shift;
                        rx_state   <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          level;
    logic                 pop;
    logic                 full;
    logic                 do_push;

    assign pop      = rx_valid && rx_ready;
    assign full     = level == (AW+1)'(FIFO_DEPTH);
    assign do_push  = rx_push && (!full || pop);
    assign rx_valid = level != '0;
    assign rx_level = level;
    assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge XCLK) begin
        if (do_push) mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge XCLK) begin
        if (!XRES) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !pop)      level <= level + 1'b1;
            else if (!do_push && pop) level <= level - 1'b1;
            // A set event in the clearing cycle keeps the flag high
            frame_err <= (frame_err && !clr_err) || fe_set;
            overrun   <= (overrun && !clr_err) || (rx_push && full && !pop);
        end
    end
endmodule

// File: tb/tb_darksocv_uart_agent.sv
// tb/tb_darksocv_uart_agent.sv - randomized loopback bench with a queue reference model
module tb_darksocv_uart_agent;
    localparam int DIV        = 16;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;
`ifdef DARKSOCV_UART_AGENT_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME_CYC = (1 + DATA_BITS + PB + STOP_BITS) * DIV;
    // Edge after a line change at which RX takes the stop sample:
    // two synchroniser flops plus edge detect, half a bit, then whole bits.
    localparam int STOP_EDGE = 3 + DIV / 2 + DIV * (DATA_BITS + PB + 1);

    logic                 clk = 1'b0;
    logic                 XRES = 1'b0;
    logic                 UART_TXD_IN;
    logic                 UART_RXD_OUT;
    logic [DATA_BITS-1:0] tx_data = '0;
    logic                 tx_valid = 1'b0;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready = 1'b0;
    logic [LW-1:0]        rx_level;
    logic                 frame_err;
    logic                 overrun;
    logic                 clr_err = 1'b0;
    logic                 loop_en = 1'b1;
    logic                 drv_line = 1'b1;

    assign UART_TXD_IN = loop_en ? UART_RXD_OUT : drv_line;

    darksocv_uart_agent #(.DIV(DIV), .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .XCLK(clk), .XRES(XRES), .UART_TXD_IN(UART_TXD_IN), .UART_RXD_OUT(UART_RXD_OUT),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_level(rx_level),
        .frame_err(frame_err), .overrun(overrun), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int                   tests = 0;
    int                   fails = 0;
    int                   pop_at = -1;
    logic [DATA_BITS-1:0] tx_q[$];
    logic [DATA_BITS-1:0] model_q[$];
    logic                 model_ovr = 1'b0;

    function automatic logic exp_line(input logic [DATA_BITS-1:0] d, input int c);
        int b;
        b = (c - 1) / DIV;
        if (b == 0) return 1'b0;
        if (b <= DATA_BITS) return d[b-1];
        if (PB == 1 && b == DATA_BITS + 1) return ^d;
        return 1'b1;
    endfunction

    function automatic void model_push(input logic [DATA_BITS-1:0] d);
        if (model_q.size() < FIFO_DEPTH) model_q.push_back(d);
        else model_ovr = 1'b1;
    endfunction

    // Sends tx_q back to back on the loopback and checks every line cycle.
    task automatic send_burst();
        logic [DATA_BITS-1:0] cur;
        int guard;
        guard = 0;
        while (tx_ready !== 1'b1 && guard < 4 * FRAME_CYC) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL tx_ready_wait: got %b expected 1", tx_ready);
        end
        while (tx_q.size() > 0) begin
            cur = tx_q.pop_front();
            tx_data = cur;
            tx_valid = 1'b1;
            for (int c = 1; c <= FRAME_CYC; c++) begin
                @(negedge clk);
                if (c == 1) tx_valid = 1'b0;
                if (c == 2 * DIV + 3) begin tx_valid = 1'b1; tx_data = ~cur; end
                if (c == 2 * DIV + 4) tx_valid = 1'b0;
                tests++;
                if (UART_RXD_OUT !== exp_line(cur, c)) begin
                    fails++;
                    $display("FAIL tx_line byte=%h cycle=%0d: got %b expected %b", cur, c, UART_RXD_OUT, exp_line(cur, c));
                end
                tests++;
                if (tx_ready !== (c == FRAME_CYC)) begin
                    fails++;
                    $display("FAIL tx_ready byte=%h cycle=%0d: got %b expected %b", cur, c, tx_ready, c == FRAME_CYC);
                end
                if (c == pop_at && model_q.size() > 0) begin
                    tests++;
                    if (rx_data !== model_q[0]) begin
                        fails++;
                        $display("FAIL coincident_pop_data: got %h expected %h", rx_data, model_q[0]);
                    end
                    model_q.delete(0);
                    rx_ready = 1'b1;
                end else begin
                    rx_ready = 1'b0;
                end
            end
            model_push(cur);
        end
    endtask

    task automatic drain();
        while (model_q.size() > 0) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            tests++;
            if (rx_level !== LW'(model_q.size())) begin
                fails++;
                $display("FAIL drain_level: got %0d expected %0d", rx_level, model_q.size());
            end
            tests++;
            if (rx_valid !== 1'b1 || rx_data !== model_q[0]) begin
                fails++;
                $display("FAIL drain_data: got valid=%b data=%h expected valid=1 data=%h", rx_valid, rx_data, model_q[0]);
            end
            model_q.delete(0);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        tests++;
        if (rx_level !== '0 || rx_valid !== 1'b0 || rx_data !== '0) begin
            fails++;
            $display("FAIL empty_pop: got level=%0d valid=%b data=%h expected 0 0 00", rx_level, rx_valid, rx_data);
        end
    endtask

    // Bit-bangs one frame on UART_TXD_IN; clr_err is pulsed at line cycle clr_at.
    task automatic drive_frame(input logic [DATA_BITS-1:0] d, input logic par_flip,
                               input logic stop_val, input int clr_at);
        int b;
        loop_en = 1'b0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            b = k / DIV;
            if (b == 0) drv_line = 1'b0;
            else if (b <= DATA_BITS) drv_line = d[b-1];
            else if (PB == 1 && b == DATA_BITS + 1) drv_line = (^d) ^ par_flip;
            else if (b == DATA_BITS + PB + 1) drv_line = stop_val;
            else drv_line = 1'b1;
            clr_err = (k == clr_at);
            @(negedge clk);
        end
        drv_line = 1'b1;
        clr_err = 1'b0;
        repeat (DIV) @(negedge clk);
        loop_en = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] exp_v;
        exp_v = {1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
        XRES = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 9) XRES = 1'b1;
            tests++;
            if ({UART_RXD_OUT, tx_ready, rx_valid, rx_level, rx_data, frame_err, overrun} !== exp_v) begin
                fails++;
                $display("FAIL reset_state cycle=%0d: got %h expected %h", i,
                         {UART_RXD_OUT, tx_ready, rx_valid, rx_level, rx_data, frame_err, overrun}, exp_v);
            end
        end
    endtask

    task automatic test_tx_loopback();
        tx_q.push_back(8'hA5);
        send_burst();
        tests++;
        if (rx_level !== LW'(1) || rx_data !== 8'hA5 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL loopback_a5: got level=%0d data=%h fe=%b expected 1 a5 0", rx_level, rx_data, frame_err);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int n;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) tx_q.push_back(DATA_BITS'($urandom));
            send_burst();
            tests++;
            if (rx_level !== LW'(model_q.size()) || overrun !== model_ovr || frame_err !== 1'b0) begin
                fails++;
                $display("FAIL burst_status it=%0d: got level=%0d ovr=%b fe=%b expected %0d %b 0",
                         it, rx_level, overrun, frame_err, model_q.size(), model_ovr);
            end
            drain();
        end
    endtask

    task automatic test_frame_err();
        drive_frame(8'h3C, 1'b0, 1'b0, -1);
        tests++;
        if (frame_err !== 1'b1 || rx_level !== '0) begin
            fails++;
            $display("FAIL stop_low: got fe=%b level=%0d expected 1 0", frame_err, rx_level);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        tests++;
        if (frame_err !== 1'b0) begin
            fails++;
            $display("FAIL clr_err: got %b expected 0", frame_err);
        end
        drive_frame(8'h3C, 1'b0, 1'b0, STOP_EDGE - 1);
        tests++;
        if (frame_err !== 1'b1) begin
            fails++;
            $display("FAIL set_beats_clear: got %b expected 1", frame_err);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        if (PB == 1) begin
            drive_frame(8'h3C, 1'b1, 1'b1, -1);
            tests++;
            if (frame_err !== 1'b1 || rx_level !== '0) begin
                fails++;
                $display("FAIL parity_err: got fe=%b level=%0d expected 1 0", frame_err, rx_level);
            end
            clr_err = 1'b1;
            @(negedge clk);
            clr_err = 1'b0;
        end
    endtask

    task automatic test_glitch();
        logic [DATA_BITS-1:0] d;
        loop_en = 1'b0;
        drv_line = 1'b0;
        repeat (3) @(negedge clk);
        drv_line = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        tests++;
        if (rx_level !== '0 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL glitch: got level=%0d valid=%b fe=%b expected 0 0 0", rx_level, rx_valid, frame_err);
        end
        d = DATA_BITS'($urandom);
        drive_frame(d, 1'b0, 1'b1, -1);
        model_push(d);
        tests++;
        if (rx_level !== LW'(1) || rx_data !== d) begin
            fails++;
            $display("FAIL after_glitch: got level=%0d data=%h expected 1 %h", rx_level, rx_data, d);
        end
        drain();
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) tx_q.push_back(DATA_BITS'(i));
        send_burst();
        tests++;
        if (rx_level !== LW'(FIFO_DEPTH) || overrun !== 1'b1 || model_ovr !== 1'b1) begin
            fails++;
            $display("FAIL overrun_full: got level=%0d ovr=%b expected %0d 1", rx_level, overrun, FIFO_DEPTH);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        model_ovr = 1'b0;
        tests++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_clr: got %b expected 0", overrun);
        end
        tx_q.push_back(8'h06);
        pop_at = STOP_EDGE;
        send_burst();
        pop_at = -1;
        tests++;
        if (rx_level !== LW'(model_q.size()) || overrun !== model_ovr) begin
            fails++;
            $display("FAIL push_pop_full: got level=%0d ovr=%b expected %0d %b", rx_level, overrun, model_q.size(), model_ovr);
        end
        drain();
    endtask

    task automatic test_reset_mid_tx();
        tx_data = '0;
        tx_valid = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        tx_valid = 1'b0;
        tests++;
        if (UART_RXD_OUT !== 1'b0 || tx_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_frame: got line=%b ready=%b expected 0 0", UART_RXD_OUT, tx_ready);
        end
        XRES = 1'b0;
        @(negedge clk);
        XRES = 1'b1;
        model_q.delete();
        model_ovr = 1'b0;
        tests++;
        if (UART_RXD_OUT !== 1'b1 || tx_ready !== 1'b1 || rx_level !== '0) begin
            fails++;
            $display("FAIL reset_abort: got line=%b ready=%b level=%0d expected 1 1 0", UART_RXD_OUT, tx_ready, rx_level);
        end
        repeat (3 * DIV) @(negedge clk);
        tests++;
        if (UART_RXD_OUT !== 1'b1 || rx_level !== '0 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL after_abort: got line=%b level=%0d fe=%b expected 1 0 0", UART_RXD_OUT, rx_level, frame_err);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_tx_loopback();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_reset_mid_tx();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
